vco_phase_gen: RTL and testbench
================================

# vco_phase_gen

Parametrised multi-channel VCO phase source. It is the successor to the single-channel, file-preloaded VCO behaviour model. Each channel produces one PHASE_WIDTH-bit phase word per enabled cycle, in one of two modes:
- replay: from a shared, run-time-writable sample table of programmable length;
- NCO: from a per-channel phase accumulator driven by a frequency control word.

It sits in front of the phase-domain quantiser/decimator path and serves as the stimulus source and synthesisable stand-in for the analog VCO.

## Interface
Parameters:
- PHASE_WIDTH, 11, phase word width
- DEPTH, 10000, sample table entries
- ADDR_WIDTH, 15, table address width; must satisfy 2^ADDR_WIDTH >= DEPTH
- NUM_CH, 2, number of independent phase channels
- FCW_WIDTH, 11, frequency control word width per channel; must be <= PHASE_WIDTH

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable_in  in  1  global advance enable
- ch_en_i  in  NUM_CH  per-channel advance enable
- mode_i  in  1  0 = replay, 1 = NCO
- len_i  in  ADDR_WIDTH  last replay index (table length minus one)
- fcw_i  in  NUM_CH*FCW_WIDTH  per-channel frequency word; channel k is at bits [k*FCW_WIDTH +: FCW_WIDTH]
- wr_en_i  in  1  table write strobe
- wr_addr_i  in  ADDR_WIDTH  table write address
- wr_data_i  in  PHASE_WIDTH  table write data
- data_o  out  NUM_CH*PHASE_WIDTH  registered phase words; channel k is at bits [k*PHASE_WIDTH +: PHASE_WIDTH]
- valid_o  out  NUM_CH  data_o channel k updated this cycle
- wrap_o  out  NUM_CH  sample on data_o is the last one before wrap

## Operation
Per-channel state:
- ptr_k (ADDR_WIDTH) and acc_k (PHASE_WIDTH); both 0 after reset.
- The table itself is not reset.

Advance condition adv_k = enable_in & ch_en_i[k]. Channels not advancing hold data_o, ptr_k and acc_k.

Replay mode (mode_i = 0), on adv_k:
- data_o[k] <= table[ptr_k].
- ptr_k <= (ptr_k >= len_eff) ? 0 : ptr_k + 1.
- wrap_o[k] <= (ptr_k >= len_eff).

NCO mode (mode_i = 1), on adv_k:
- data_o[k] <= acc_k.
- acc_k <= acc_k + zero-extended fcw_k, modulo 2^PHASE_WIDTH.
- wrap_o[k] <= carry out of that addition.

Length and table rules:
- len_eff = min(len_i, DEPTH-1); len_i is sampled every cycle.
- Lowering len_i below ptr_k forces ptr_k to 0 on the next advance, with wrap_o = 1.
- wr_en_i writes table[wr_addr_i] every cycle it is high, regardless of mode or enable. Writes with wr_addr_i >= DEPTH are ignored.
- A read and write to the same address in the same cycle return the old data (read-before-write).

Mode change:
- A change of mode_i (registered copy differs from input) clears all ptr_k and acc_k in that cycle.
- No channel advances in that cycle; valid_o = 0 and wrap_o = 0.
- data_o holds its value.

valid_o[k] = registered adv_k, except 0 in a mode-change cycle.

## Timing
- Reset (rst_n low, asynchronous): data_o = 0, valid_o = 0, wrap_o = 0, ptr_k = 0, acc_k = 0, and the registered mode = 0. Outputs remain 0 until the first clock edge after release at which a channel advances.
- Latency: one cycle. The sample indexed at edge t appears on data_o after edge t, together with valid_o and wrap_o.
- Throughput: one sample per channel per enabled cycle. No back-pressure.
- wrap_o and valid_o are single-cycle pulses. They are asserted only on cycles where valid_o is high.
- Table writes take effect for reads at the next edge.
- rst_n deasserted mid-run: the sequence restarts from index 0 / phase 0. Table contents are preserved.

## Test plan
- Replay wrap: load table[i] = i for i = 0..4, len_i = 4, one channel enabled continuously. Required data_o sequence: 0,1,2,3,4,0,1. wrap_o is high only with each 4. valid_o is high every cycle.
- NCO overflow: PHASE_WIDTH = 11, fcw = 512, mode_i = 1. Required data_o sequence: 0,512,1024,1536,0. wrap_o is high with 1536. Also check fcw = 0, which must hold data_o = 0 with no wrap.
- Independent channels: NCO mode, fcw0 = 3, fcw1 = 5, ch_en_i toggled to 2'b01 for 2 cycles. Required: channel 1 holds data_o and has valid_o[1] = 0 while channel 0 continues 0,3,6. Channel 1 then resumes from its held acc.
- Mode switch mid-run: in replay at ptr = 3, flip mode_i to 1. Required: one cycle with valid_o = 0. The next sample is 0 (acc cleared). Flipping back to replay restarts at table[0].
- Length shrink and clamp: running with ptr = 7, set len_i = 2. Required: the next sample is table[7] with wrap_o = 1, followed by table[0..2] wrapping. Then set len_i = 20000 with DEPTH = 10000 and check wrap occurs after index 9999.
- Async reset and write collision: assert rst_n low between clock edges. Required: outputs are 0 immediately (before the next edge) and table data is intact after release. Separately, write table[0] = 99 while reading index 0. Required: the old value is seen that pass and 99 is seen on the next pass.

Source files
------------

// File: rtl/vco_phase_gen.sv
`default_nettype none
// ============================================================================
// vco_phase_gen : multi-channel VCO phase source (table replay or NCO per cycle)
// Rev 1.0
// ============================================================================
module vco_phase_gen #(
    parameter int PHASE_WIDTH = 11,
    parameter int DEPTH       = 10000,
    parameter int ADDR_WIDTH  = 15,
    parameter int NUM_CH      = 2,
    parameter int FCW_WIDTH   = 11
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable_in,
    input  logic [NUM_CH-1:0]             ch_en_i,
    input  logic                          mode_i,
    input  logic [ADDR_WIDTH-1:0]         len_i,
    input  logic [NUM_CH*FCW_WIDTH-1:0]   fcw_i,
    input  logic                          wr_en_i,
    input  logic [ADDR_WIDTH-1:0]         wr_addr_i,
    input  logic [PHASE_WIDTH-1:0]        wr_data_i,
    output logic [NUM_CH*PHASE_WIDTH-1:0] data_o,
    output logic [NUM_CH-1:0]             valid_o,
    output logic [NUM_CH-1:0]             wrap_o
);
    localparam int                    IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    logic [PHASE_WIDTH-1:0] table_q [DEPTH];
    logic                   mode_q;
    logic                   mode_chg;
    logic [ADDR_WIDTH-1:0]  len_eff;

    assign mode_chg = (mode_i != mode_q);
    assign len_eff  = (len_i > LAST_IDX) ? LAST_IDX : len_i;

    // Table has no reset so its contents survive rst_n; reads see pre-write data.
    always_ff @(posedge clk) begin
        if (wr_en_i && (wr_addr_i <= LAST_IDX)) begin
            table_q[wr_addr_i[IDX_W-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode_i;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
        logic [PHASE_WIDTH-1:0] acc_q, acc_d;
        logic [PHASE_WIDTH-1:0] data_q, data_d;
        logic                   valid_q, valid_d;
        logic                   wrap_q, wrap_d;
        logic [PHASE_WIDTH:0]   nco_sum;
        logic                   ptr_at_end;

        assign nco_sum    = {1'b0, acc_q}
                          + {{(PHASE_WIDTH + 1 - FCW_WIDTH){1'b0}}, fcw_i[k*FCW_WIDTH +: FCW_WIDTH]};
        // >= rather than == so a shrunken length forces the pointer home.
        assign ptr_at_end = (ptr_q >= len_eff);

        always_comb begin
            ptr_d   = ptr_q;
            acc_d   = acc_q;
            data_d  = data_q;
            valid_d = 1'b0;
            wrap_d  = 1'b0;
            if (mode_chg) begin
                ptr_d = '0;
                acc_d = '0;
            end else if (enable_in && ch_en_i[k]) begin
                valid_d = 1'b1;
                if (mode_i) begin
                    data_d = acc_q;
                    acc_d  = nco_sum[PHASE_WIDTH-1:0];
                    wrap_d = nco_sum[PHASE_WIDTH];
                end else begin
                    data_d = table_q[ptr_q[IDX_W-1:0]];
                    wrap_d = ptr_at_end;
                    ptr_d  = ptr_at_end ? '0 : ptr_q + ADDR_WIDTH'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ptr_q   <= '0;
                acc_q   <= '0;
                data_q  <= '0;
                valid_q <= 1'b0;
                wrap_q  <= 1'b0;
            end else begin
                ptr_q   <= ptr_d;
                acc_q   <= acc_d;
                data_q  <= data_d;
                valid_q <= valid_d;
                wrap_q  <= wrap_d;
            end
        end

        assign data_o[k*PHASE_WIDTH +: PHASE_WIDTH] = data_q;
        assign valid_o[k]                           = valid_q;
        assign wrap_o[k]                            = wrap_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_vco_phase_gen.sv
`default_nettype none
// ============================================================================
// tb_vco_phase_gen : directed + randomized checks of vco_phase_gen
// Rev 1.0
// ============================================================================
module tb_vco_phase_gen;
    localparam int PW    = 11;
    localparam int DEPTH = 10000;
    localparam int AW    = 15;
    localparam int NCH   = 2;
    localparam int FW    = 11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [NCH-1:0]    ch_en;
    logic              mode;
    logic [AW-1:0]     len;
    logic [NCH*FW-1:0] fcw;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [PW-1:0]     wr_data;
    logic [NCH*PW-1:0] data_o;
    logic [NCH-1:0]    valid_o;
    logic [NCH-1:0]    wrap_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_tbl [DEPTH];
    int m_ptr [NCH];
    int m_acc [NCH];
    int m_data[NCH];
    bit m_valid[NCH];
    bit m_wrap [NCH];
    bit m_mode;

    vco_phase_gen #(
        .PHASE_WIDTH(PW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .NUM_CH(NCH), .FCW_WIDTH(FW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable_in(en), .ch_en_i(ch_en), .mode_i(mode),
        .len_i(len), .fcw_i(fcw), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .data_o(data_o), .valid_o(valid_o), .wrap_o(wrap_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dch(input int k);
        return 32'(data_o[k*PW +: PW]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_ptr[k] = 0; m_acc[k] = 0; m_data[k] = 0; m_valid[k] = 0; m_wrap[k] = 0;
        end
        m_mode = 0;
    endtask

    // Apply current inputs for one edge, advance the model, then compare.
    task automatic step();
        int le, s;
        le = (int'(len) > DEPTH - 1) ? DEPTH - 1 : int'(len);
        for (int k = 0; k < NCH; k++) begin
            m_valid[k] = 0;
            m_wrap[k]  = 0;
            if (mode != m_mode) begin
                m_ptr[k] = 0;
                m_acc[k] = 0;
            end else if (en && ch_en[k]) begin
                m_valid[k] = 1;
                if (!mode) begin
                    m_data[k] = m_tbl[m_ptr[k]];
                    m_wrap[k] = (m_ptr[k] >= le);
                    m_ptr[k]  = m_wrap[k] ? 0 : m_ptr[k] + 1;
                end else begin
                    m_data[k] = m_acc[k];
                    s         = m_acc[k] + int'(fcw[k*FW +: FW]);
                    m_wrap[k] = (s >= (1 << PW));
                    m_acc[k]  = s % (1 << PW);
                end
            end
        end
        m_mode = mode;
        if (wr_en && int'(wr_addr) < DEPTH) m_tbl[wr_addr] = int'(wr_data);
        @(posedge clk);
        #1;
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("data_ch%0d", k),  dch(k),            32'(m_data[k]));
            chk($sformatf("valid_ch%0d", k), 32'(valid_o[k]),   32'(m_valid[k]));
            chk($sformatf("wrap_ch%0d", k),  32'(wrap_o[k]),    32'(m_wrap[k]));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"},  32'(data_o),  32'd0);
        chk({tag, "_valid"}, 32'(valid_o), 32'd0);
        chk({tag, "_wrap"},  32'(wrap_o),  32'd0);
    endtask

    initial begin
        int exp_a[7];
        int exp_b[5];
        int old0;
        exp_a = '{0, 1, 2, 3, 4, 0, 1};
        exp_b = '{0, 512, 1024, 1536, 0};

        rst_n = 1'b0; en = 1'b0; ch_en = '0; mode = 1'b0; len = AW'(4);
        fcw = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        model_reset();
        #12;
        chk_zero("reset");
        rst_n = 1'b1;

        // Fill whole table; outputs must stay idle while disabled
        wr_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_addr = AW'(i);
            wr_data = (i < 5) ? PW'(i) : PW'($urandom);
            step();
        end
        wr_en = 1'b0;

        // Replay wrap
        en = 1'b1; ch_en = 2'b01; len = AW'(4);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("A_data",  dch(0),           32'(exp_a[i]));
            chk("A_wrap",  32'(wrap_o[0]),   32'(i == 4));
            chk("A_valid", 32'(valid_o[0]),  32'd1);
        end

        // NCO overflow, fcw0=512, fcw1=0
        mode = 1'b1; ch_en = 2'b11;
        fcw[0 +: FW] = FW'(512); fcw[FW +: FW] = '0;
        step();
        chk("B_modechg_valid", 32'(valid_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("B_data0", dch(0),          32'(exp_b[i]));
            chk("B_wrap0", 32'(wrap_o[0]),  32'(i == 3));
            chk("B_data1", dch(1),          32'd0);
            chk("B_wrap1", 32'(wrap_o[1]),  32'd0);
        end

        // Independent channels
        mode = 1'b0; step();
        mode = 1'b1; step();
        fcw[0 +: FW] = FW'(3); fcw[FW +: FW] = FW'(5);
        ch_en = 2'b11; step(); step();
        ch_en = 2'b01;
        step();
        chk("C_data0", dch(0), 32'd6);
        chk("C_hold1", dch(1), 32'd5);
        chk("C_valid1", 32'(valid_o[1]), 32'd0);
        step();
        ch_en = 2'b11;
        step();
        chk("C_resume0", dch(0), 32'd12);
        chk("C_resume1", dch(1), 32'd10);

        // Mode switch mid-run
        mode = 1'b0; ch_en = 2'b01; len = AW'(9);
        step();
        step(); step(); step();
        mode = 1'b1;
        step();
        chk("D_chg_valid", 32'(valid_o[0]), 32'd0);
        chk("D_hold",      dch(0),          32'd2);
        step();
        chk("D_nco_first", dch(0), 32'd0);
        mode = 1'b0;
        step();
        chk("D_chg2_valid", 32'(valid_o[0]), 32'd0);
        step();
        chk("D_replay_restart", dch(0), 32'(m_tbl[0]));

        // Length shrink, then clamp to DEPTH-1
        len = AW'(20);
        for (int i = 0; i < 6; i++) step();
        len = AW'(2);
        step();
        chk("E_shrink_data", dch(0),         32'(m_tbl[7]));
        chk("E_shrink_wrap", 32'(wrap_o[0]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("E_small_wrap", 32'(wrap_o[0]), 32'(i == 2));
        end
        len = AW'(20000);
        for (int i = 0; i < DEPTH; i++) begin
            step();
            chk("E_clamp_wrap", 32'(wrap_o[0]), 32'(i == DEPTH - 1));
        end
        step();
        chk("E_after_clamp", dch(0), 32'(m_tbl[0]));

        // Randomized phase, including writes aliasing above DEPTH
        for (int i = 0; i < 400; i++) begin
            en      = ($urandom % 4) != 0;
            ch_en   = NCH'($urandom);
            if ($urandom % 16 == 0) mode = ~mode;
            len     = AW'($urandom % 32);
            fcw     = (NCH*FW)'($urandom);
            wr_en   = $urandom % 2;
            wr_addr = AW'((($urandom % 2) ? 16384 : 0) + ($urandom % 32));
            wr_data = PW'($urandom);
            step();
        end
        wr_en = 1'b0;

        // Async reset mid-cycle, table preserved
        en = 1'b1; ch_en = 2'b11; mode = 1'b0; len = AW'(4);
        step(); step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        model_reset();
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();

        // Write collision at index 0
        ch_en = 2'b01;
        for (int i = 0; i < 5 && m_ptr[0] != 0; i++) step();
        chk("G_ptr_home", 32'(m_ptr[0]), 32'd0);
        old0 = m_tbl[0];
        wr_en = 1'b1; wr_addr = '0; wr_data = PW'(99);
        step();
        chk("G_old_value", dch(0), 32'(old0));
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) step();
        step();
        chk("G_new_value", dch(0), 32'd99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
